// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the EX/MEM stage and dmem_responder.
interface dmem_responder_if;
    logic [31:0] D_MEM_ADDR;
    logic [3:0]  D_MEM_BE;
    logic        D_MEM_WEN;
    logic        D_MemRead;
    logic [31:0] D_MEM_DI;
    logic [31:0] D_MEM_DOUT;
    logic        D_MEM_STALL;
    logic        D_MEM_DONE;
    logic        D_MEM_ERR;

    modport master (
        output D_MEM_ADDR, D_MEM_BE, D_MEM_WEN, D_MemRead, D_MEM_DI,
        input  D_MEM_DOUT, D_MEM_STALL, D_MEM_DONE, D_MEM_ERR
    );

    modport slave (
        input  D_MEM_ADDR, D_MEM_BE, D_MEM_WEN, D_MemRead, D_MEM_DI,
        output D_MEM_DOUT, D_MEM_STALL, D_MEM_DONE, D_MEM_ERR
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory with IDLE/WAIT/RESP handshake and byte-lane enables.
// Optional DMEM_ALIGN_CHECK_EN turns unaligned byte-enable patterns into error completions.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input logic             CLK,
    input logic             RSTn,
    dmem_responder_if.slave dmem
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       di_q, di_d;
    logic              wr_q, wr_d;
    logic              bad_q, bad_d;
    logic [31:0]       dout_q, dout_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0]       mem [2**ADDR_W];
    logic              req, be_bad, access, mem_we;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{dmem.D_MEM_ADDR[1:0], dmem.D_MEM_ADDR[31:ADDR_W+2]};

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        unique case (dmem.D_MEM_BE)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_bad = 1'b0;
            default:                   be_bad = 1'b1;
        endcase
    end
`else
    assign be_bad = 1'b0;
`endif

    // The *_d request fields equal the live inputs when sampled in IDLE and the
    // latched copy in WAIT, so the access below serves both LATENCY=0 and >0.
    always_comb begin
        req     = dmem.D_MemRead | ~dmem.D_MEM_WEN;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        di_d    = di_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d = dmem.D_MEM_ADDR[ADDR_W+1:2];
                    be_d   = dmem.D_MEM_BE;
                    di_d   = dmem.D_MEM_DI;
                    wr_d   = ~dmem.D_MEM_WEN;
                    bad_d  = (dmem.D_MemRead & ~dmem.D_MEM_WEN) | be_bad;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (access) begin
            done_d = 1'b1;
            err_d  = bad_d;
            if (bad_d)      dout_d = '0;
            else if (!wr_d) dout_d = mem[addr_d] & lane_mask(be_d);
        end
        mem_we = access & wr_d & ~bad_d;
    end

    always_ff @(posedge CLK) begin
        if (RSTn && mem_we)
            mem[addr_d] <= (mem[addr_d] & ~lane_mask(be_d)) | (di_d & lane_mask(be_d));
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            di_q    <= '0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            di_q    <= di_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dmem.D_MEM_DOUT  = dout_q;
    assign dmem.D_MEM_DONE  = done_q;
    assign dmem.D_MEM_ERR   = err_q;
    assign dmem.D_MEM_STALL = RSTn & (((state_q == IDLE) & req) | (state_q == WAIT));
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 10; word-address width, giving 2^ADDR_W 32-bit words of storage.
REQ-002 Parameter LATENCY, default 2, legal range 0..7; number of WAIT cycles inserted per access.
REQ-003 CLK  in  1  clock; all state changes on posedge CLK.
REQ-004 RSTn  in  1  reset, synchronous, active-low.
REQ-005 D_MEM_ADDR  in  32  byte address from the EX/MEM register; bits [ADDR_W+1:2] select the word, bits [1:0] are ignored.
REQ-006 D_MEM_BE  in  4  byte-lane enables; bit i selects bits [8i+7:8i].
REQ-007 D_MEM_WEN  in  1  write request, active-low.
REQ-008 D_MemRead  in  1  read request, active-high.
REQ-009 D_MEM_DI  in  32  store data, already lane-aligned.
REQ-010 D_MEM_DOUT  out  32  read data, registered.
REQ-011 D_MEM_STALL  out  1  pipeline hold, combinational.
REQ-012 D_MEM_DONE  out  1  one-cycle access-complete pulse, registered.
REQ-013 D_MEM_ERR  out  1  access-error flag; valid only while D_MEM_DONE=1.

Function
REQ-014 A request is present when D_MemRead=1 or D_MEM_WEN=0.
REQ-015 The FSM has three states: IDLE, WAIT and RESP.
REQ-016 In IDLE, a present request is latched (ADDR, BE, DI and type); the next state is WAIT with counter=LATENCY-1, or RESP directly if LATENCY=0.
REQ-017 In WAIT, the counter decrements each cycle; when the counter is 0, the next state is RESP.
REQ-018 The memory access occurs on the edge entering RESP:
- a write updates only the lanes whose BE bit is 1;
- a read loads D_MEM_DOUT with the addressed word, forcing lanes whose BE bit is 0 to 8'h00.
REQ-019 In RESP, D_MEM_DONE=1 for exactly one cycle; the next state is always IDLE.
REQ-020 Any request present during RESP is ignored and is sampled again in IDLE on the following cycle.
REQ-021 D_MEM_STALL=1 in two cases: in IDLE while a request is present, and in WAIT. D_MEM_STALL=0 in RESP and in IDLE with no request.
REQ-022 Latency: a request first seen in cycle 0 produces D_MEM_DONE in cycle LATENCY+1 and releases the stall in that same cycle.
REQ-023 D_MEM_DOUT holds its value until the next completed read; writes do not alter D_MEM_DOUT.
REQ-024 A request with D_MemRead=1 and D_MEM_WEN=0 together is an error: no memory change, DOUT is loaded with 0, and DONE and ERR pulse together.
REQ-025 The latched request is not affected by input changes after the IDLE sample edge.
REQ-026 The word address wraps modulo 2^ADDR_W; address bits above ADDR_W+1 are ignored.

Reset
REQ-027 While RSTn=0 at a posedge, the block SHALL set: state=IDLE, counter=0, D_MEM_DOUT=0, D_MEM_DONE=0, D_MEM_ERR=0.
REQ-028 Memory contents are not reset.
REQ-029 Reset asserted in WAIT aborts the access; a pending write is never performed.
REQ-030 D_MEM_STALL=0 during reset, regardless of request inputs.

Configuration
REQ-031 With DMEM_ALIGN_CHECK_EN defined, BE values other than 0001, 0010, 0100, 1000, 0011, 1100 and 1111 cause an error completion, handled as in REQ-024: write suppressed, DOUT=0, ERR=1 with DONE.
REQ-032 Without DMEM_ALIGN_CHECK_EN, any BE is accepted as-is, and D_MEM_ERR is tied to 0 except for the REQ-024 read+write conflict.

Verification
REQ-033 LATENCY=2; write ADDR=0x10, BE=1111, DI=0xDEADBEEF; then read ADDR=0x10 -> STALL high for 3 cycles, DONE in cycle 3, DOUT=0xDEADBEEF.
REQ-034 Partial write ADDR=0x10, BE=0010, DI=0x0000AA00; then read with BE=1111 -> DOUT=0xDEADAAEF.
REQ-035 LATENCY=0; back-to-back reads of 0x0 and 0x4 held per the stall -> DONE every 2nd cycle, STALL pattern 1,0,1,0.
REQ-036 D_MemRead=1 with D_MEM_WEN=0 at ADDR=0x20 -> DONE=1, ERR=1, DOUT=0, memory word 0x20 unchanged.
REQ-037 RSTn=0 during WAIT of a write of 0x12345678 to 0x30 -> read of 0x30 after reset returns its prior value; DONE never pulses for the aborted write.
REQ-038 With DMEM_ALIGN_CHECK_EN defined, write with BE=0101 -> ERR=1 and memory unchanged; without the macro, the same write updates lanes 0 and 2.
